// File: rtl/count_7seg_display.sv
// Purpose: binary-to-BCD converter (sequential double-dabble) driving a muxed 3-digit 7-seg display.
// Latency: 9 cycles from a count change seen in IDLE to bcd_valid/bcd; display is combinational from bcd.
// Backpressure: none; count changes during a conversion are ignored and picked up afterwards.
//
// Ports:
//   clk        block clock (same domain as the counter driving count)
//   rst        synchronous, active-low reset
//   count      8-bit unsigned value to display
//   bcd        last converted value {hundreds, tens, ones}
//   bcd_valid  one-cycle pulse when bcd is updated
//   seg        segments {g,f,e,d,c,b,a}, polarity set by COMMON_ANODE
//   dp         decimal point, always off
//   an         one-hot digit enables [0] ones, [1] tens, [2] hundreds
module count_7seg_display #(
  parameter logic [15:0] REFRESH_DIV  = 16'd1,
  parameter bit          COMMON_ANODE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  count,
  output logic [11:0] bcd,
  output logic        bcd_valid,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [2:0]  an
);

  typedef enum logic {IDLE, CONV} state_t;

  state_t      state, state_next;
  logic [7:0]  shown_bin;
  logic [7:0]  src;
  logic [19:0] shift;
  logic [19:0] shift_adj;
  logic [19:0] shift_next;
  logic [2:0]  iter;
  logic        load;
  logic        done;
  logic [15:0] prescale;
  logic [1:0]  digit;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // One double-dabble step: correct each BCD nibble, then shift in the next binary bit.
  always_comb begin
    shift_adj  = {add3(shift[19:16]), add3(shift[15:12]), add3(shift[11:8]), shift[7:0]};
    shift_next = {shift_adj[18:0], 1'b0};
  end

  // Converter FSM: state register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Converter FSM: next state and control strobes
  always_comb begin
    state_next = state;
    load       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (count != shown_bin) begin
          load       = 1'b1;
          state_next = CONV;
        end
      end
      CONV: begin
        if (iter == 3'd7) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Converter datapath. src holds the value being converted so shown_bin
  // reflects what was actually converted, not what count is now.
  always_ff @(posedge clk) begin
    if (!rst) begin
      shown_bin <= 8'd0;
      src       <= 8'd0;
      shift     <= 20'd0;
      iter      <= 3'd0;
      bcd       <= 12'd0;
      bcd_valid <= 1'b0;
    end else begin
      bcd_valid <= done;
      if (load) begin
        src   <= count;
        shift <= {12'b0, count};
        iter  <= 3'd0;
      end else if (state == CONV) begin
        shift <= shift_next;
        iter  <= iter + 3'd1;
      end
      if (done) begin
        bcd       <= shift_next[19:8];
        shown_bin <= src;
      end
    end
  end

  // Display refresh: prescaler wraps every REFRESH_DIV cycles and advances the digit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      prescale <= 16'd0;
      digit    <= 2'd0;
    end else if (prescale == REFRESH_DIV - 16'd1) begin
      prescale <= 16'd0;
      digit    <= (digit == 2'd2) ? 2'd0 : digit + 2'd1;
    end else begin
      prescale <= prescale + 16'd1;
    end
  end

  logic [3:0] nib;
  logic       blank;
  logic [2:0] an_hi;
  logic [6:0] seg_hi;

  // Digit select and leading-zero blanking; a blank digit keeps its anode enabled.
  always_comb begin
    nib   = 4'd0;
    blank = 1'b1;
    an_hi = 3'b000;
    case (digit)
      2'd0: begin
        nib   = bcd[3:0];
        blank = 1'b0;
        an_hi = 3'b001;
      end
      2'd1: begin
        nib   = bcd[7:4];
        blank = (bcd[11:8] == 4'd0) && (bcd[7:4] == 4'd0);
        an_hi = 3'b010;
      end
      2'd2: begin
        nib   = bcd[11:8];
        blank = (bcd[11:8] == 4'd0);
        an_hi = 3'b100;
      end
      default: begin
        nib   = 4'd0;
        blank = 1'b1;
        an_hi = 3'b000;
      end
    endcase
  end

  // Active-high segment decode; nibbles 10..15 never occur and decode blank.
  always_comb begin
    seg_hi = 7'b0000000;
    if (!blank) begin
      case (nib)
        4'd0:    seg_hi = 7'b0111111;
        4'd1:    seg_hi = 7'b0000110;
        4'd2:    seg_hi = 7'b1011011;
        4'd3:    seg_hi = 7'b1001111;
        4'd4:    seg_hi = 7'b1100110;
        4'd5:    seg_hi = 7'b1101101;
        4'd6:    seg_hi = 7'b1111101;
        4'd7:    seg_hi = 7'b0000111;
        4'd8:    seg_hi = 7'b1111111;
        4'd9:    seg_hi = 7'b1101111;
        default: seg_hi = 7'b0000000;
      endcase
    end
  end

  always_comb begin
    seg = COMMON_ANODE ? ~seg_hi : seg_hi;
    an  = COMMON_ANODE ? ~an_hi  : an_hi;
    dp  = COMMON_ANODE ? 1'b1    : 1'b0;
  end

endmodule
